// File: rtl/apb_bridge_pkg.sv
// Shared definitions for the AHB-to-APB bridge controller: FSM state
// encoding and AHB response codes.
package apb_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WDATA  = 3'd1,
    ST_SETUP  = 3'd2,
    ST_ACCESS = 3'd3,
    ST_ERR1   = 3'd4,
    ST_ERR2   = 3'd5
  } state_t;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

endpackage

// File: rtl/apb_wait_timer.sv
// APB ACCESS-phase wait counter. Cleared when the bridge enters SETUP,
// counts every ACCESS cycle, and flags the last permitted ACCESS cycle.
// Only instantiated when APB_TIMEOUT_EN is defined.
module apb_wait_timer #(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic hclk,
  input  logic hresetn,
  input  logic clr,
  input  logic en,
  output logic expired
);

  // Counter holds 0..WAIT_MAX-1; the bridge leaves ACCESS once it hits the top.
  localparam int unsigned CNT_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WAIT_MAX - 1);

  logic [CNT_W-1:0] cnt;

  // Count ACCESS cycles since the last SETUP entry.
  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Asserted during the WAIT_MAX-th ACCESS cycle.
  always_comb begin
    expired = en && (cnt == LAST);
  end

endmodule

// File: rtl/apb_bridge_ctrl.sv
// AHB-to-APB bridge controller. One transfer at a time: IDLE captures the
// request, WDATA picks up the AHB data phase for writes, then the APB
// SETUP/ACCESS phases run. Decode or slave errors produce the two-cycle
// AHB ERROR response (ERR1/ERR2).
// Optional build macro: APB_TIMEOUT_EN -- aborts ACCESS to ERR1 after
// WAIT_MAX cycles without pready.
module apb_bridge_ctrl
  import apb_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NSLV     = 4,
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic              valid,
  input  logic              hwrite,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [DATA_W-1:0] hwdata,
  input  logic [NSLV-1:0]   temp_sel,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr,
  output logic [NSLV-1:0]   psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] hrdata,
  output logic [1:0]        hresp,
  output logic              hready_out
);

  if (WAIT_MAX < 1) begin : g_bad_wait_max
    $error("apb_bridge_ctrl: WAIT_MAX must be at least 1");
  end

  state_t          state;
  state_t          state_nxt;
  logic [NSLV-1:0] sel_q;
  logic [NSLV-1:0] sel_src;
  logic            sel_onehot;
  logic            timeout;

  // Exactly one slave decoded: non-zero and no second bit set.
  always_comb begin
    sel_onehot = (temp_sel != '0) && ((temp_sel & (temp_sel - NSLV'(1))) == '0);
  end

  // Read transfers go IDLE->SETUP in one edge, so psel must come straight
  // from the decode input that edge rather than from the captured copy.
  always_comb begin
    sel_src = (state == ST_IDLE) ? temp_sel : sel_q;
  end

`ifdef APB_TIMEOUT_EN
  apb_wait_timer #(
    .WAIT_MAX(WAIT_MAX)
  ) u_wait_timer (
    .hclk   (hclk),
    .hresetn(hresetn),
    .clr    (state_nxt == ST_SETUP),
    .en     (state == ST_ACCESS),
    .expired(timeout)
  );
`else
  always_comb begin
    timeout = 1'b0;
  end
`endif

  // State register.
  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and the state-decoded AHB response outputs.
  always_comb begin
    state_nxt  = state;
    hready_out = 1'b1;
    hresp      = HRESP_OKAY;
    case (state)
      ST_IDLE: begin
        if (valid) begin
          if (!sel_onehot) begin
            state_nxt = ST_ERR1;
          end else if (hwrite) begin
            state_nxt = ST_WDATA;
          end else begin
            state_nxt = ST_SETUP;
          end
        end
      end
      ST_WDATA: begin
        hready_out = 1'b0;
        state_nxt  = ST_SETUP;
      end
      ST_SETUP: begin
        hready_out = 1'b0;
        state_nxt  = ST_ACCESS;
      end
      ST_ACCESS: begin
        hready_out = 1'b0;
        if (pready) begin
          state_nxt = pslverr ? ST_ERR1 : ST_IDLE;
        end else if (timeout) begin
          state_nxt = ST_ERR1;
        end
      end
      ST_ERR1: begin
        hready_out = 1'b0;
        hresp      = HRESP_ERROR;
        state_nxt  = ST_ERR2;
      end
      ST_ERR2: begin
        hresp     = HRESP_ERROR;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Registered APB/AHB datapath: request capture, APB strobes, read return.
  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      sel_q   <= '0;
      psel    <= '0;
      penable <= 1'b0;
      pwrite  <= 1'b0;
      paddr   <= '0;
      pwdata  <= '0;
      hrdata  <= '0;
    end else begin
      if (state == ST_IDLE && valid) begin
        sel_q  <= temp_sel;
        paddr  <= haddr;
        pwrite <= hwrite;
      end
      if (state == ST_WDATA) begin
        pwdata <= hwdata;
      end
      if (state == ST_ACCESS && pready && !pslverr && !pwrite) begin
        hrdata <= prdata;
      end
      // Strobes are driven from the upcoming state so they line up with it.
      psel    <= (state_nxt == ST_SETUP || state_nxt == ST_ACCESS) ? sel_src : '0;
      penable <= (state_nxt == ST_ACCESS);
    end
  end

endmodule

// File: tb/tb_apb_bridge_ctrl.sv
// Directed, table-driven bench for apb_bridge_ctrl (NSLV=4, 32-bit buses).
// Each vector row: inputs held for one cycle, outputs expected in that cycle.
module tb_apb_bridge_ctrl;

  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int NSLV     = 4;
  localparam int WAIT_MAX = 15;

  localparam logic [31:0] DB = 32'hDEADBEEF;
  localparam logic [31:0] W1 = 32'h12345678;
  localparam logic [31:0] W2 = 32'hA5A5A5A5;

  logic              hclk = 1'b0;
  logic              hresetn;
  logic              valid;
  logic              hwrite;
  logic [ADDR_W-1:0] haddr;
  logic [DATA_W-1:0] hwdata;
  logic [NSLV-1:0]   temp_sel;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;
  logic [NSLV-1:0]   psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] hrdata;
  logic [1:0]        hresp;
  logic              hready_out;

  always #5 hclk = ~hclk;

  apb_bridge_ctrl #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .NSLV    (NSLV),
    .WAIT_MAX(WAIT_MAX)
  ) dut (
    .hclk      (hclk),
    .hresetn   (hresetn),
    .valid     (valid),
    .hwrite    (hwrite),
    .haddr     (haddr),
    .hwdata    (hwdata),
    .temp_sel  (temp_sel),
    .prdata    (prdata),
    .pready    (pready),
    .pslverr   (pslverr),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .hrdata    (hrdata),
    .hresp     (hresp),
    .hready_out(hready_out)
  );

  typedef struct {
    logic        rstn;
    logic        valid;
    logic        hwrite;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic [3:0]  sel;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic [3:0]  e_psel;
    logic        e_pen;
    logic        e_pwrite;
    logic [31:0] e_paddr;
    logic [31:0] e_pwdata;
    logic [31:0] e_hrdata;
    logic [1:0]  e_hresp;
    logic        e_hrdy;
  } vec_t;

  vec_t vecs[$];
  int   nvec = 0;
  int   nerr = 0;
  int   acc;

  function automatic void push(
    input int unsigned rstn, vld, wr, addr, wdata, sel, rdata, rdy, err,
    input int unsigned e_psel, e_pen, e_pwrite, e_paddr, e_pwdata, e_hrdata, e_hresp, e_hrdy
  );
    vec_t v;
    v.rstn     = rstn[0];
    v.valid    = vld[0];
    v.hwrite   = wr[0];
    v.haddr    = addr;
    v.hwdata   = wdata;
    v.sel      = sel[3:0];
    v.prdata   = rdata;
    v.pready   = rdy[0];
    v.pslverr  = err[0];
    v.e_psel   = e_psel[3:0];
    v.e_pen    = e_pen[0];
    v.e_pwrite = e_pwrite[0];
    v.e_paddr  = e_paddr;
    v.e_pwdata = e_pwdata;
    v.e_hrdata = e_hrdata;
    v.e_hresp  = e_hresp[1:0];
    v.e_hrdy   = e_hrdy[0];
    vecs.push_back(v);
  endfunction

  task automatic check_vec(input int idx, input vec_t v);
    nvec++;
    if ({psel, penable, pwrite, paddr, pwdata, hrdata, hresp, hready_out} !==
        {v.e_psel, v.e_pen, v.e_pwrite, v.e_paddr, v.e_pwdata, v.e_hrdata, v.e_hresp, v.e_hrdy}) begin
      nerr++;
      $display("FAIL vec%0d: got psel=%b penable=%b pwrite=%b paddr=%h pwdata=%h hrdata=%h hresp=%b hready=%b, expected psel=%b penable=%b pwrite=%b paddr=%h pwdata=%h hrdata=%h hresp=%b hready=%b",
               idx, psel, penable, pwrite, paddr, pwdata, hrdata, hresp, hready_out,
               v.e_psel, v.e_pen, v.e_pwrite, v.e_paddr, v.e_pwdata, v.e_hrdata, v.e_hresp, v.e_hrdy);
    end
  endtask

  task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  initial begin
    // Args: rstn,valid,hwrite,haddr,hwdata,sel,prdata,pready,pslverr,
    //       psel,penable,pwrite,paddr,pwdata,hrdata,hresp,hready
    push(1,0,0,0,0,'b0000,0,0,0,       'b0000,0,0,0,0,0,0,1);          // 0 reset state
    // Zero-wait read, slave 1
    push(1,1,0,'h40,0,'b0010,0,0,0,    'b0000,0,0,0,0,0,0,1);          // 1 T
    push(1,0,0,0,0,0,0,0,0,            'b0010,0,0,'h40,0,0,0,0);       // 2 SETUP
    push(1,0,0,0,0,0,DB,1,0,           'b0010,1,0,'h40,0,0,0,0);       // 3 ACCESS
    push(1,0,0,0,0,0,0,0,0,            'b0000,0,0,'h40,0,DB,0,1);      // 4 done
    // Write, 3 wait states; valid in SETUP must be ignored
    push(1,1,1,'h100,0,'b0100,0,0,0,   'b0000,0,0,'h40,0,DB,0,1);      // 5 T
    push(1,0,0,0,W1,0,0,0,0,           'b0000,0,1,'h100,0,DB,0,0);     // 6 WDATA
    push(1,1,0,'h200,0,'b0001,0,0,0,   'b0100,0,1,'h100,W1,DB,0,0);    // 7 SETUP
    push(1,0,0,0,0,0,0,0,0,            'b0100,1,1,'h100,W1,DB,0,0);    // 8 ACCESS
    push(1,0,0,0,0,0,0,0,0,            'b0100,1,1,'h100,W1,DB,0,0);    // 9
    push(1,0,0,0,0,0,0,0,0,            'b0100,1,1,'h100,W1,DB,0,0);    // 10
    push(1,0,0,0,0,0,'hBAD0BAD0,1,0,   'b0100,1,1,'h100,W1,DB,0,0);    // 11
    push(1,0,0,0,0,0,0,0,0,            'b0000,0,1,'h100,W1,DB,0,1);    // 12 T+7
    // Read with slave error
    push(1,1,0,'h80,0,'b1000,0,0,0,    'b0000,0,1,'h100,W1,DB,0,1);    // 13 T
    push(1,0,0,0,0,0,0,0,0,            'b1000,0,0,'h80,W1,DB,0,0);     // 14
    push(1,0,0,0,0,0,'h55AA55AA,1,1,   'b1000,1,0,'h80,W1,DB,0,0);     // 15
    push(1,0,0,0,0,0,0,0,0,            'b0000,0,0,'h80,W1,DB,1,0);     // 16 ERR1
    push(1,0,0,0,0,0,0,0,0,            'b0000,0,0,'h80,W1,DB,1,1);     // 17 ERR2
    push(1,0,0,0,0,0,0,0,0,            'b0000,0,0,'h80,W1,DB,0,1);     // 18 IDLE
    // Bad decode: zero-hot, then multi-hot
    push(1,1,1,'h300,0,'b0000,0,0,0,   'b0000,0,0,'h80,W1,DB,0,1);     // 19
    push(1,0,0,0,0,0,0,0,0,            'b0000,0,1,'h300,W1,DB,1,0);    // 20
    push(1,0,0,0,0,0,0,0,0,            'b0000,0,1,'h300,W1,DB,1,1);    // 21
    push(1,1,0,'h304,0,'b0110,0,0,0,   'b0000,0,1,'h300,W1,DB,0,1);    // 22
    push(1,0,0,0,0,0,0,0,0,            'b0000,0,0,'h304,W1,DB,1,0);    // 23
    push(1,0,0,0,0,0,0,0,0,            'b0000,0,0,'h304,W1,DB,1,1);    // 24
    push(1,0,0,0,0,0,0,0,0,            'b0000,0,0,'h304,W1,DB,0,1);    // 25
    // Reset during ACCESS
    push(1,1,0,'h44,0,'b0001,0,0,0,    'b0000,0,0,'h304,W1,DB,0,1);    // 26
    push(1,0,0,0,0,0,0,0,0,            'b0001,0,0,'h44,W1,DB,0,0);     // 27
    push(0,0,0,0,0,0,0,0,0,            'b0001,1,0,'h44,W1,DB,0,0);     // 28
    push(1,0,0,0,0,0,0,0,0,            'b0000,0,0,0,0,0,0,1);          // 29 aborted
    // Zero-wait write after reset
    push(1,1,1,'h10,0,'b0001,0,0,0,    'b0000,0,0,0,0,0,0,1);          // 30 T
    push(1,0,0,0,W2,0,0,0,0,           'b0000,0,1,'h10,0,0,0,0);       // 31
    push(1,0,0,0,0,0,0,0,0,            'b0001,0,1,'h10,W2,0,0,0);      // 32
    push(1,0,0,0,0,0,0,1,0,            'b0001,1,1,'h10,W2,0,0,0);      // 33
    push(1,0,0,0,0,0,0,0,0,            'b0000,0,1,'h10,W2,0,0,1);      // 34 T+4

    hresetn  = 1'b0;
    valid    = 1'b0;
    hwrite   = 1'b0;
    haddr    = '0;
    hwdata   = '0;
    temp_sel = '0;
    prdata   = '0;
    pready   = 1'b0;
    pslverr  = 1'b0;
    repeat (2) @(posedge hclk);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge hclk);
      hresetn  = vecs[i].rstn;
      valid    = vecs[i].valid;
      hwrite   = vecs[i].hwrite;
      haddr    = vecs[i].haddr;
      hwdata   = vecs[i].hwdata;
      temp_sel = vecs[i].sel;
      prdata   = vecs[i].prdata;
      pready   = vecs[i].pready;
      pslverr  = vecs[i].pslverr;
      #1;
      check_vec(i, vecs[i]);
    end

    // Read with pready held low: count ACCESS cycles, bounded at 100.
    @(negedge hclk);
    valid    = 1'b1;
    hwrite   = 1'b0;
    haddr    = 32'h60;
    temp_sel = 4'b0010;
    pready   = 1'b0;
    pslverr  = 1'b0;
    @(negedge hclk);
    valid = 1'b0;
    check1("stall_setup_psel", 32'(psel), 32'h2);
    acc = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge hclk);
      if (penable) acc++;
      else break;
    end
`ifdef APB_TIMEOUT_EN
    check1("timeout_access_cycles", acc, WAIT_MAX);
    check1("timeout_err1_hresp", 32'(hresp), 32'h1);
    check1("timeout_err1_hready", 32'(hready_out), 32'h0);
    check1("timeout_err1_psel", 32'(psel), 32'h0);
    @(negedge hclk);
    check1("timeout_err2_hresp", 32'(hresp), 32'h1);
    check1("timeout_err2_hready", 32'(hready_out), 32'h1);
    @(negedge hclk);
    check1("timeout_idle_hresp", 32'(hresp), 32'h0);
`else
    check1("stall_access_cycles", acc, 100);
    check1("stall_hresp", 32'(hresp), 32'h0);
    check1("stall_hready", 32'(hready_out), 32'h0);
    check1("stall_psel", 32'(psel), 32'h2);
    check1("stall_paddr", paddr, 32'h60);
    prdata = 32'hCAFEF00D;
    pready = 1'b1;
    @(negedge hclk);
    pready = 1'b0;
    check1("stall_done_hrdata", hrdata, 32'hCAFEF00D);
    check1("stall_done_hready", 32'(hready_out), 32'h1);
    check1("stall_done_penable", 32'(penable), 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/apb_bridge_ctrl.md
APB_BRIDGE_CTRL -- requirements
Module: apb_bridge_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, APB/AHB data width.
REQ-003 SHALL have parameter NSLV, default 4, number of APB slaves (psel width).
REQ-004 SHALL have parameter WAIT_MAX, default 15, maximum ACCESS cycles before timeout.
REQ-005 SHALL have port hclk  in  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port hresetn  in  1  reset, synchronous, active-low.
REQ-007 SHALL have ports valid, hwrite  in  1  each: AHB transfer request and direction.
REQ-008 SHALL have ports haddr [ADDR_W], hwdata [DATA_W], temp_sel [NSLV], all inputs: address, write data, one-hot slave decode.
REQ-009 SHALL have ports prdata [DATA_W], pready [1], pslverr [1], all inputs from the APB slave.
REQ-010 SHALL have registered outputs psel [NSLV], penable [1], pwrite [1], paddr [ADDR_W], pwdata [DATA_W], hrdata [DATA_W].
REQ-011 SHALL have outputs hresp [2] (00 OKAY, 01 ERROR) and hready_out [1].

Function
REQ-012 SHALL implement states IDLE, WDATA, SETUP, ACCESS, ERR1, ERR2.
REQ-013 IDLE: hready_out=1, psel=0, penable=0; on valid=1, capture haddr, hwrite and temp_sel.
REQ-014 IDLE transitions: temp_sel not one-hot (zero or multi-hot) -> ERR1 with no APB access; write -> WDATA; read -> SETUP.
REQ-015 WDATA: hready_out=0; capture hwdata into pwdata; transition -> SETUP.
REQ-016 SETUP: psel=captured sel, penable=0, paddr/pwrite valid; transition -> ACCESS after one cycle.
REQ-017 ACCESS: penable=1, hready_out=0; hold psel, paddr, pwrite and pwdata stable while pready=0.
REQ-018 ACCESS exits:
- pready=1 and pslverr=0 -> IDLE; on a read, register prdata into hrdata on the same edge.
- pready=1 and pslverr=1 -> ERR1.
REQ-019 ERR1: hresp=01, hready_out=0. ERR2: hresp=01, hready_out=1. Both drop psel and penable. ERR1->ERR2->IDLE unconditionally.
REQ-020 Latency, with zero wait states and valid sampled in IDLE at cycle T:
- read: SETUP T+1, ACCESS T+2, hready_out=1 with hrdata valid at T+3.
- write: completes at T+4.
REQ-021 hresp SHALL be 00 in every state except ERR1 and ERR2.
REQ-022 valid SHALL be ignored outside IDLE; no second transfer is buffered.

Reset
REQ-023 When hresetn=0 at a clock edge, state -> IDLE; psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, hrdata=0, hresp=00, hready_out=1.
REQ-024 Reset mid-transfer (SETUP/ACCESS/ERR) SHALL abort with no completion response; the APB signals go inactive at that edge.

Configuration
REQ-025 With APB_TIMEOUT_EN defined:
- an ACCESS-cycle counter clears on SETUP entry.
- reaching WAIT_MAX with pready=0 SHALL drop psel/penable and go to ERR1.
REQ-026 Without APB_TIMEOUT_EN, ACCESS SHALL wait indefinitely for pready and WAIT_MAX is unused.

Structure
REQ-027 Shared package apb_bridge_pkg SHALL hold the state enum and the HRESP_OKAY/HRESP_ERROR constants.
REQ-028 Timeout counter SHALL be sub-module apb_wait_timer, instantiated only under APB_TIMEOUT_EN.

Verification
REQ-029 Read, NSLV=4, temp_sel=0010, haddr=0x40, prdata=0xDEADBEEF, pready=1 -> psel=0010 at T+1, penable at T+2, hrdata=0xDEADBEEF and hready_out=1 at T+3.
REQ-030 Write, hwdata=0x12345678, 3 wait states -> pwdata=0x12345678 and paddr stable across all 4 ACCESS cycles; completion at T+7.
REQ-031 Read with pslverr=1 at pready -> hresp=01 for 2 cycles, hready_out 0 then 1, then IDLE with hresp=00.
REQ-032 temp_sel=0000 or 0110 -> no psel asserted, two-cycle ERROR response.
REQ-033 APB_TIMEOUT_EN, WAIT_MAX=15, pready held 0 -> ERR1 entered after 15 ACCESS cycles. Without the macro -> still in ACCESS after 100 cycles.
REQ-034 hresetn=0 during ACCESS -> next edge psel=0, penable=0, hready_out=1, state IDLE.
